change_dispenser: RTL

Sequencer that pays out a change amount, in cents, as physical coins through a single coin-hopper eject interface. It sits between the vending machine credit/price logic and the hopper driver. Given a start pulse and an amount, it ejects coins greedily (largest first), one at a time, using a four-phase request/acknowledge handshake with a timeout. It reports progress, completion and hopper faults.

---
 rtl/change_dispenser.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout sequencer driving a four-phase hopper eject handshake.
// Build option: define CHANGE_DISPENSER_DOLLAR_COIN_EN to let the dollar coin take part in selection.
module change_dispenser #(
    parameter int AMT_W   = 10,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             eject_ack,
    output logic             eject_req,
    output logic [1:0]       coin_sel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [AMT_W-1:0] remaining,
    output logic [7:0]       coins_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_REQ,
        S_RELEASE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

`ifdef CHANGE_DISPENSER_DOLLAR_COIN_EN
    localparam logic [3:0] COIN_EN = 4'b1111;
`else
    localparam logic [3:0] COIN_EN = 4'b0111;
`endif

    function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] sel);
        case (sel)
            2'd0:    coin_value = AMT_W'(5);
            2'd1:    coin_value = AMT_W'(10);
            2'd2:    coin_value = AMT_W'(25);
            default: coin_value = AMT_W'(100);
        endcase
    endfunction

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_coin_sel;
    logic [1:0]       w_sel_next;
    logic [AMT_W-1:0] r_remaining;
    logic [AMT_W-1:0] w_remaining_next;
    logic [7:0]       r_coins_out;
    logic [7:0]       w_coins_next;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_next;
    logic             r_eject_req;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [3:0]       w_fits;
    logic [1:0]       w_pick;

    // A coin fits when it is enabled in this build and does not exceed what is still owed.
    for (genvar gi = 0; gi < 4; gi++) begin : g_fit
        assign w_fits[gi] = COIN_EN[gi] && (r_remaining >= coin_value(2'(gi)));
    end

    always_comb begin
        w_pick = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_fits[i]) begin
                w_pick = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_sel_next       = r_coin_sel;
        w_remaining_next = r_remaining;
        w_coins_next     = r_coins_out;
        w_wait_next      = 8'd0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_remaining_next = amount;
                    w_coins_next     = 8'd0;
                    w_state_next     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (|w_fits) begin
                    w_sel_next   = w_pick;
                    w_state_next = S_REQ;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_REQ: begin
                if (eject_ack) begin
                    w_remaining_next = r_remaining - coin_value(r_coin_sel);
                    w_coins_next     = (r_coins_out == 8'hFF) ? r_coins_out : r_coins_out + 8'd1;
                    w_state_next     = S_RELEASE;
                end else if (r_wait_cnt == TIMEOUT_CNT) begin
                    w_state_next = S_ERROR;
                end else begin
                    w_wait_next = r_wait_cnt + 8'd1;
                end
            end
            S_RELEASE: begin
                if (!eject_ack) begin
                    w_state_next = S_SELECT;
                end else if (r_wait_cnt == TIMEOUT_CNT) begin
                    w_state_next = S_ERROR;
                end else begin
                    w_wait_next = r_wait_cnt + 8'd1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            S_ERROR: begin
                w_state_next = S_ERROR;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_coin_sel  <= 2'd0;
            r_remaining <= '0;
            r_coins_out <= 8'd0;
            r_wait_cnt  <= 8'd0;
            r_eject_req <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_coin_sel  <= w_sel_next;
            r_remaining <= w_remaining_next;
            r_coins_out <= w_coins_next;
            r_wait_cnt  <= w_wait_next;
            r_eject_req <= (w_state_next == S_REQ);
            r_busy      <= (w_state_next == S_SELECT) || (w_state_next == S_REQ) ||
                           (w_state_next == S_RELEASE);
            r_done      <= (w_state_next == S_DONE);
            r_err       <= (w_state_next == S_ERROR);
        end
    end

    assign eject_req = r_eject_req;
    assign coin_sel  = r_coin_sel;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign remaining = r_remaining;
    assign coins_out = r_coins_out;

endmodule
